// File: rtl/cga_video_gen.sv
// Low-res raster generator: stage-0 counters and framebuffer fetch, stage-1 timing
// delay (the RAM output register is the data half of stage 1), stage-2 registered video.
module cga_video_gen #(
   parameter int unsigned H_ACTIVE     = 256,
   parameter int unsigned H_SYNC_START = 288,
   parameter int unsigned H_SYNC_LEN   = 32,
   parameter int unsigned H_TOTAL      = 384,
   parameter int unsigned V_ACTIVE     = 240,
   parameter int unsigned V_SYNC_START = 248,
   parameter int unsigned V_SYNC_LEN   = 4,
   parameter int unsigned V_TOTAL      = 262
) (
   input  logic        clk6m,
   input  logic        reset,
   output logic [15:0] fb_addr,
   output logic        fb_rd,
   input  logic [8:0]  fb_data,
   output logic        hsync_o,
   output logic        vsync_o,
   output logic        hblank_o,
   output logic        vblank_o,
   output logic [8:0]  rgb_o,
   output logic        frame_o,
   output logic [8:0]  hcount_o,
   output logic [8:0]  vcount_o
);

   localparam int unsigned CW   = 9;
   localparam int unsigned RGBW = 9;
   localparam int unsigned AW   = 16;
   localparam int unsigned EW   = CW + 1;

   // Sync windows end at START+LEN, which may equal 512, so compare one bit wider
   localparam logic [EW-1:0] HS_BEGIN = EW'(H_SYNC_START);
   localparam logic [EW-1:0] HS_END   = EW'(H_SYNC_START + H_SYNC_LEN);
   localparam logic [EW-1:0] VS_BEGIN = EW'(V_SYNC_START);
   localparam logic [EW-1:0] VS_END   = EW'(V_SYNC_START + V_SYNC_LEN);

   logic [CW-1:0]   h_q, h_d, v_q, v_d;
   logic [AW-1:0]   addr_hold_q, addr_hold_d;
   logic [AW-1:0]   addr_now;
   logic            vis0, hs0, vs0;

   logic            hs_s1_q, hs_s1_d, vs_s1_q, vs_s1_d;
   logic            hb_s1_q, hb_s1_d, vb_s1_q, vb_s1_d;
   logic            vis_s1_q, vis_s1_d, frame_s1_q, frame_s1_d;

   logic            hsync_q, hsync_d, vsync_q, vsync_d;
   logic            hblank_q, hblank_d, vblank_q, vblank_d;
   logic [RGBW-1:0] rgb_q, rgb_d;
   logic            frame_q, frame_d;

   // Counters, fetch address and the two pipeline stages
   always_comb begin
      h_d = h_q + CW'(1);
      v_d = v_q;
      if (h_q == CW'(H_TOTAL - 1)) begin
         h_d = '0;
         v_d = (v_q == CW'(V_TOTAL - 1)) ? '0 : v_q + CW'(1);
      end

      vis0 = (h_q < CW'(H_ACTIVE)) && (v_q < CW'(V_ACTIVE));
      hs0  = (EW'(h_q) >= HS_BEGIN) && (EW'(h_q) < HS_END);
      vs0  = (EW'(v_q) >= VS_BEGIN) && (EW'(v_q) < VS_END);

      // No read is issued while reset is held, even though the counters sit in the visible area
      fb_rd       = vis0 && !reset;
      addr_now    = {v_q[7:0], h_q[7:0]};
      addr_hold_d = fb_rd ? addr_now : addr_hold_q;
      fb_addr     = addr_hold_d;

      hs_s1_d    = hs0;
      vs_s1_d    = vs0;
      hb_s1_d    = (h_q >= CW'(H_ACTIVE));
      vb_s1_d    = (v_q >= CW'(V_ACTIVE));
      vis_s1_d   = vis0;
      frame_s1_d = (h_q == '0) && (v_q == '0);

      hsync_d  = ~hs_s1_q;
      vsync_d  = ~vs_s1_q;
      hblank_d = hb_s1_q;
      vblank_d = vb_s1_q;
      rgb_d    = vis_s1_q ? fb_data : '0;
      frame_d  = frame_s1_q;
   end

   always_ff @(posedge clk6m) begin
      if (reset) begin
         h_q         <= '0;
         v_q         <= '0;
         addr_hold_q <= '0;
         hs_s1_q     <= 1'b0;
         vs_s1_q     <= 1'b0;
         hb_s1_q     <= 1'b1;
         vb_s1_q     <= 1'b1;
         vis_s1_q    <= 1'b0;
         frame_s1_q  <= 1'b0;
         hsync_q     <= 1'b1;
         vsync_q     <= 1'b1;
         hblank_q    <= 1'b1;
         vblank_q    <= 1'b1;
         rgb_q       <= '0;
         frame_q     <= 1'b0;
      end else begin
         h_q         <= h_d;
         v_q         <= v_d;
         addr_hold_q <= addr_hold_d;
         hs_s1_q     <= hs_s1_d;
         vs_s1_q     <= vs_s1_d;
         hb_s1_q     <= hb_s1_d;
         vb_s1_q     <= vb_s1_d;
         vis_s1_q    <= vis_s1_d;
         frame_s1_q  <= frame_s1_d;
         hsync_q     <= hsync_d;
         vsync_q     <= vsync_d;
         hblank_q    <= hblank_d;
         vblank_q    <= vblank_d;
         rgb_q       <= rgb_d;
         frame_q     <= frame_d;
      end
   end

   assign hsync_o  = hsync_q;
   assign vsync_o  = vsync_q;
   assign hblank_o = hblank_q;
   assign vblank_o = vblank_q;
   assign rgb_o    = rgb_q;
   assign frame_o  = frame_q;
   assign hcount_o = h_q;
   assign vcount_o = v_q;

endmodule

// File: tb/tb_cga_video_gen.sv
// Scoreboard bench for cga_video_gen on a scaled raster; the reference model works on a
// linear pixel position within the frame and a framebuffer array.
`timescale 1ns/1ps
module tb_cga_video_gen;

   localparam int HA = 16, HSS = 20, HSL = 4, HT = 32;
   localparam int VA = 10, VSS = 12, VSL = 2, VT = 14;
   localparam int FT = HT * VT;

   logic        clk6m = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] fb_addr;
   logic        fb_rd;
   logic [8:0]  fb_data = '0;
   logic        hsync_o, vsync_o, hblank_o, vblank_o, frame_o;
   logic [8:0]  rgb_o, hcount_o, vcount_o;

   cga_video_gen #(
      .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL), .H_TOTAL(HT),
      .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL), .V_TOTAL(VT)
   ) dut (
      .clk6m(clk6m), .reset(reset), .fb_addr(fb_addr), .fb_rd(fb_rd), .fb_data(fb_data),
      .hsync_o(hsync_o), .vsync_o(vsync_o), .hblank_o(hblank_o), .vblank_o(vblank_o),
      .rgb_o(rgb_o), .frame_o(frame_o), .hcount_o(hcount_o), .vcount_o(vcount_o)
   );

   always #5 clk6m = ~clk6m;

   // Framebuffer: one-cycle read latency, garbage on the bus when not reading
   logic [8:0] mem [0:65535];
   always @(posedge clk6m) fb_data <= fb_rd ? mem[fb_addr] : 9'($urandom);

   typedef struct {
      bit hs, vs, hb, vb, fr, rd;
      int rgb, addr, hc, vc;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_vis(input int p);
      return ((p % HT) < HA) && ((p / HT) < VA);
   endfunction

   function automatic int addr_of(input int p);
      return ((p / HT) % 256) * 256 + ((p % HT) % 256);
   endfunction

   function automatic exp_t vid(input int p, input int data);
      exp_t e;
      int h, v;
      h = p % HT;
      v = p / HT;
      e.hs  = !(h >= HSS && h < HSS + HSL);
      e.vs  = !(v >= VSS && v < VSS + VSL);
      e.hb  = (h >= HA);
      e.vb  = (v >= VA);
      e.fr  = (p == 0);
      e.rgb = is_vis(p) ? data : 0;
      return e;
   endfunction

   function automatic exp_t rst_vals();
      exp_t e;
      e.hs = 1; e.vs = 1; e.hb = 1; e.vb = 1; e.fr = 0; e.rgb = 0;
      return e;
   endfunction

   // Model state after edge n: positions/data for n, n-1, n-2 and reset for n, n-1
   int pos0 = 0, pos1 = 0, pos2 = 0;
   int dat1 = 0, dat2 = 0;
   bit rst0 = 1, rst1 = 1;
   int hold = 0;

   task automatic fill(input int mode);
      for (int a = 0; a < 65536; a++) begin
         case (mode)
            0:       mem[a] = 9'(a);
            1:       mem[a] = 9'($urandom);
            default: mem[a] = 9'h1FF;
         endcase
      end
   endtask

   // Push expectations for the current cycle, then apply reset value rn to the next edge
   task automatic cycle(input bit rn);
      exp_t e;
      bit   rd;
      int   a, d0;
      if (rst0 || rst1) e = rst_vals();
      else              e = vid(pos2, dat2);
      a      = addr_of(pos0);
      rd     = is_vis(pos0) && !rn;
      e.rd   = rd;
      e.addr = rd ? a : hold;
      e.hc   = pos0 % HT;
      e.vc   = pos0 / HT;
      sb.push_back(e);
      d0   = int'(mem[a]);
      hold = rn ? 0 : (rd ? a : hold);
      pos2 = pos1;
      pos1 = pos0;
      pos0 = rn ? 0 : (pos0 + 1) % FT;
      dat2 = dat1;
      dat1 = d0;
      rst1 = rst0;
      rst0 = rn;
      reset = rn;
      @(posedge clk6m);
      #1;
   endtask

   // Monitor: per-cycle scoreboard compare plus period checks over reset-free windows
   int cyc = 0;
   int last_fr = -1, last_hfall = -1, hlow_start = -1, vlow_start = -1;
   bit clean_f = 0, clean_h = 0, clean_v = 0;
   bit prev_hs = 1, prev_vs = 1;
   exp_t me;

   always @(negedge clk6m) begin
      if (sb.size() > 0) begin
         me = sb.pop_front();
         chk("hsync_o",  32'(hsync_o),  32'(me.hs));
         chk("vsync_o",  32'(vsync_o),  32'(me.vs));
         chk("hblank_o", 32'(hblank_o), 32'(me.hb));
         chk("vblank_o", 32'(vblank_o), 32'(me.vb));
         chk("frame_o",  32'(frame_o),  32'(me.fr));
         chk("rgb_o",    32'(rgb_o),    32'(me.rgb));
         chk("fb_rd",    32'(fb_rd),    32'(me.rd));
         chk("fb_addr",  32'(fb_addr),  32'(me.addr));
         chk("hcount_o", 32'(hcount_o), 32'(me.hc));
         chk("vcount_o", 32'(vcount_o), 32'(me.vc));
      end
      if (frame_o === 1'b1) begin
         if (clean_f && last_fr >= 0) chk("frame_period", 32'(cyc - last_fr), 32'(FT));
         last_fr = cyc;
         clean_f = 1;
      end
      if (prev_hs === 1'b1 && hsync_o === 1'b0) begin
         if (clean_h && last_hfall >= 0) chk("hsync_period", 32'(cyc - last_hfall), 32'(HT));
         last_hfall = cyc;
         hlow_start = cyc;
         clean_h = 1;
      end
      if (prev_hs === 1'b0 && hsync_o === 1'b1 && clean_h)
         chk("hsync_low_len", 32'(cyc - hlow_start), 32'(HSL));
      if (prev_vs === 1'b1 && vsync_o === 1'b0) begin
         if (clean_f) chk("vsync_offset", 32'(cyc - last_fr), 32'(VSS * HT));
         vlow_start = cyc;
         clean_v = 1;
      end
      if (prev_vs === 1'b0 && vsync_o === 1'b1 && clean_v)
         chk("vsync_low_len", 32'(cyc - vlow_start), 32'(VSL * HT));
      if (reset) begin
         clean_f = 0;
         clean_h = 0;
         clean_v = 0;
      end
      prev_hs = hsync_o;
      prev_vs = vsync_o;
      cyc++;
   end

   initial begin
      fill(0);
      @(posedge clk6m);
      #1;
      // Address-pattern framebuffer after a 5-cycle reset
      for (int i = 0; i < 4; i++) cycle(1'b1);
      for (int i = 0; i < 2 * FT + 50; i++) cycle(1'b0);
      // Random framebuffer contents with sporadic resets
      fill(1);
      for (int i = 0; i < 2 * FT; i++) cycle(1'($urandom_range(399) == 0));
      for (int i = 0; i < FT + 10; i++) cycle(1'b0);
      // Single-cycle reset in the middle of the visible area
      for (int i = 0; i < FT && pos0 != 5 * HT + 7; i++) cycle(1'b0);
      cycle(1'b1);
      for (int i = 0; i < FT + 50; i++) cycle(1'b0);
      // Constant white framebuffer
      fill(2);
      for (int i = 0; i < 2 * FT + 50; i++) cycle(1'b0);
      @(negedge clk6m);
      @(negedge clk6m);
      chk("scoreboard_drain", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
